// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage MIPS pipeline.
// Merges the load-use hazard, the EX taken-branch and the data-memory
// handshake into PC / inter-stage freeze and flush controls, with a
// memory-wait watchdog.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters).
// Handshake: a memory access is complete in any cycle where mem_req=1 and
// mem_ready=1; mem_req=1 with mem_ready=0 stalls the pipe until mem_ready=1
// or the watchdog expires.
// o_dbg_state exposes the FSM state (0=RUN, 1=MEM_WAIT, 2=BR_FLUSH).
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_freeze,
    output logic        if2id_freeze,
    output logic        if2id_flush,
    output logic        id2ex_flush,
    output logic        back_freeze,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_BR_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] BR_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic [2:0] r_br_cnt;

    logic w_mem_stall;
    logic w_timeout;
    logic w_br_start;

    assign w_mem_stall = mem_req & ~mem_ready;
    // Watchdog fires only while still waiting; a ready in the same cycle wins.
    assign w_timeout   = (r_state == ST_MEM_WAIT) & ~mem_ready & (r_wait_cnt == TO_LAST);
    // A taken branch is only accepted in RUN when no memory stall overrides it.
    assign w_br_start  = (r_state == ST_RUN) & ~w_mem_stall & branch_taken;
    assign o_dbg_state = r_state;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection following RUN priority: memory, branch, hazard.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (branch_taken && MULTI_FLUSH) begin
                    w_next_state = ST_BR_FLUSH;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready || w_timeout) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_BR_FLUSH: begin
                if (w_mem_stall) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (r_br_cnt == 3'd1) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Control outputs; all forced low while reset is asserted.
    always_comb begin
        pc_freeze    = 1'b0;
        if2id_freeze = 1'b0;
        if2id_flush  = 1'b0;
        id2ex_flush  = 1'b0;
        back_freeze  = 1'b0;
        mem_timeout  = 1'b0;
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        pc_freeze    = 1'b1;
                        if2id_freeze = 1'b1;
                        back_freeze  = 1'b1;
                    end else if (branch_taken) begin
                        if2id_flush  = 1'b1;
                        id2ex_flush  = 1'b1;
                    end else if (hazard_detected) begin
                        pc_freeze    = 1'b1;
                        if2id_freeze = 1'b1;
                        id2ex_flush  = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_timeout) begin
                        mem_timeout  = 1'b1;
                    end else if (!mem_ready) begin
                        pc_freeze    = 1'b1;
                        if2id_freeze = 1'b1;
                        back_freeze  = 1'b1;
                    end
                end
                ST_BR_FLUSH: begin
                    if (w_mem_stall) begin
                        pc_freeze    = 1'b1;
                        if2id_freeze = 1'b1;
                        back_freeze  = 1'b1;
                    end else begin
                        if2id_flush  = 1'b1;
                        id2ex_flush  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Wait and flush-length counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
            r_br_cnt   <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_wait_cnt <= 8'd0;
                    end else if (branch_taken && MULTI_FLUSH) begin
                        r_br_cnt   <= BR_LOAD;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready || w_timeout) begin
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_BR_FLUSH: begin
                    if (w_mem_stall) begin
                        r_wait_cnt <= 8'd0;
                        r_br_cnt   <= 3'd0;
                    end else begin
                        r_br_cnt   <= r_br_cnt - 3'd1;
                    end
                end
                default: begin
                    r_wait_cnt <= 8'd0;
                    r_br_cnt   <= 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    // Saturating performance counters for freeze cycles and branch flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (pc_freeze && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_br_start && (r_flush_events != 16'hFFFF)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 16'd0;
`endif

endmodule
